uart_tx_slave: RTL and testbench

UART_TX_SLAVE -- requirements
Module: uart_tx_slave

---
 rtl/uart_tx_slave.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_slave.sv
// ---------------------------------------------------------------------------
// uart_tx_slave : memory-mapped 8N1 UART transmitter with a small TX FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package MemoryBus;
  typedef struct packed {
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;

  typedef struct packed {
    logic [31:0] read_data;
  } Result;
endpackage

module uart_tx_slave #(
  parameter int DIVISOR    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  MemoryBus::Cmd    membuscmd,
  output MemoryBus::Result membusres,
  output logic             tx
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic w_full;
  logic w_empty;
  logic w_baud_end;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_ovf_clr;
  logic w_ovf_set;
  logic w_unused;

  assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_baud_end = (r_baud == 16'(DIVISOR - 1));
  // A pop only ever happens on the edge that starts a frame.
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));
  assign w_push_req = rst && membuscmd.mem_write && membuscmd.mask_byte[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_clr  = membuscmd.mem_write && membuscmd.mask_byte[1] && membuscmd.write_data[8];
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_unused   = ^{membuscmd.address, membuscmd.mem_read,
                        membuscmd.write_data[31:9], membuscmd.mask_byte[3:2]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= membuscmd.write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
      if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= START;
            r_shift <= r_mem[r_rptr];
            r_tx    <= 1'b0;
            r_baud  <= '0;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_baud  <= '0;
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state <= START;
              r_shift <= r_mem[r_rptr];
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = r_tx;

  always_comb begin
    membusres.read_data = 32'h0000_0002;
    if (rst) begin
      membusres.read_data = {23'd0, 5'(r_count), r_ovf, (r_state != IDLE), w_empty, w_full};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_slave.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_slave : vector table, directed corner sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_slave;

  localparam int c_DIV   = 4;
  localparam int c_DEPTH = 4;
  localparam int c_FRAME = 10 * c_DIV;

  logic             clk;
  logic             rst;
  MemoryBus::Cmd    cmd;
  MemoryBus::Result res;
  logic             tx;

  uart_tx_slave #(.DIVISOR(c_DIV), .FIFO_DEPTH(c_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .membuscmd (cmd),
    .membusres (res),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: FIFO as a queue, line as "frame in progress + cycles elapsed".
  logic [7:0] m_q[$];
  logic       m_ovf    = 1'b0;
  logic       m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic we, input logic [3:0] m, input logic [31:0] d);
    logic frame_end, pop, preq, accept;
    if (!r) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      frame_end = m_active && (m_pos == c_FRAME - 1);
      pop       = (m_q.size() > 0) && (!m_active || frame_end);
      preq      = we && m[0];
      accept    = preq && ((m_q.size() < c_DEPTH) || pop);
      if (m_active) m_pos++;
      if (frame_end) m_active = 1'b0;
      if (pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (accept) m_q.push_back(d[7:0]);
      if (we && m[1] && d[8]) m_ovf = 1'b0;
      else if (preq && !accept) m_ovf = 1'b1;
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / c_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!rst) return 32'h0000_0002;
    return {23'd0, 5'(m_q.size()), m_ovf, m_active, (m_q.size() == 0), (m_q.size() == c_DEPTH)};
  endfunction

  task automatic step(input logic r, input logic we, input logic rd, input logic [3:0] m, input logic [31:0] d);
    rst            = r;
    cmd.address    = $urandom;
    cmd.mem_read   = rd;
    cmd.mem_write  = we;
    cmd.mask_byte  = m;
    cmd.write_data = d;
    @(posedge clk);
    model_edge(r, we, m, d);
    #1;
    chk("model_tx", {31'd0, tx}, {31'd0, exp_tx()});
    chk("model_status", res.read_data, exp_rd());
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, 4'h1, d);
  endtask

  typedef struct {
    logic        r;
    logic        we;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] ers;
    logic        etx;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [9:0] fr;
    int guard, first_busy, last_busy, lows;

    rst = 1'b0;
    cmd = '0;

    vecs[0]  = '{1'b0, 1'b0, 4'h0, 32'h000, 32'h02, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 32'h0A1, 32'h10, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 4'h1, 32'h0A2, 32'h14, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'h1, 32'h0A3, 32'h24, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h1, 32'h0A4, 32'h34, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'h1, 32'h0A5, 32'h45, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'h1, 32'h0A6, 32'h4D, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 4'h2, 32'h100, 32'h45, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 32'h1FF, 32'h45, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'h000, 32'h02, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h000, 32'h02, 1'b1};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].we, 1'b0, vecs[i].m, vecs[i].d);
      chk($sformatf("vec%0d_status", i), res.read_data, vecs[i].ers);
      chk($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vecs[i].etx});
    end

    // Single frame of 0x55: exact line waveform over 40 cycles.
    fr = {1'b1, 8'h55, 1'b0};
    wr(32'h55);
    for (int i = 0; i < c_FRAME; i++) begin
      idle();
      chk($sformatf("frame55_c%0d", i), {31'd0, tx}, {31'd0, fr[i / c_DIV]});
    end
    idle();
    chk("frame55_after_tx", {31'd0, tx}, 32'd1);
    chk("frame55_after_status", res.read_data, 32'h2);

    // Three back-to-back frames, busy span must be 120 cycles with no gap.
    first_busy = -1;
    last_busy  = -1;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) wr(32'h41);
      else if (i == 1) wr(32'h42);
      else if (i == 2) begin
        wr(32'h43);
        chk("b2b_count_after_3", {27'd0, res.read_data[8:4]}, 32'd2);
      end else idle();
      if (res.read_data[2]) begin
        if (first_busy < 0) first_busy = i;
        last_busy = i;
      end else if (first_busy >= 0 && i < first_busy + 3 * c_FRAME) begin
        chk("b2b_gap", 32'd1, 32'd0);
      end
    end
    chk("b2b_span", last_busy - first_busy + 1, 3 * c_FRAME);

    // Write to a full FIFO on the same edge the next frame pops.
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) wr(32'h11 + i);
    guard = 0;
    while (!(m_active && m_pos == c_FRAME - 1) && guard < 100) begin
      idle();
      guard++;
    end
    chk("full_pop_wait", {31'd0, (m_active && m_pos == c_FRAME - 1)}, 32'd1);
    wr(32'h77);
    chk("full_pop_status", res.read_data, 32'h45);
    chk("full_pop_tx", {31'd0, tx}, 32'd0);

    // Bus reads mid-frame return status in the same cycle.
    idle();
    cmd.mem_read = 1'b1;
    #1;
    chk("read_midframe", res.read_data, exp_rd());
    cmd.mem_read = 1'b0;

    // Reset during data bit 3 aborts the frame and discards the FIFO.
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    idle();
    wr(32'hC3);
    wr(32'h3C);
    guard = 0;
    while (!(m_active && (m_pos / c_DIV) == 4) && guard < 100) begin
      idle();
      guard++;
    end
    chk("rst_mid_wait", {31'd0, (m_active && (m_pos / c_DIV) == 4)}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_status", res.read_data, 32'h2);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      idle();
      if (tx !== 1'b1) lows++;
    end
    chk("rst_mid_silent", lows, 0);
    chk("rst_mid_final_status", res.read_data, 32'h2);

    // Random traffic against the reference model.
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 800) != 0, ($urandom % 4) == 0, $urandom % 2,
           4'($urandom % 16), {$urandom, 9'h0} | 32'($urandom % 512));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
